// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down modulo counter with parallel load,
// cascade terminal count, optional saturation and sticky overflow flag.
module param_updown_counter #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
   parameter bit              SATURATE = 1'b0,
   parameter bit              CHECK_EN = 1'b1
) (
   input  logic             clk,
   input  logic             MR,
   input  logic             Enable,
   input  logic             Load,
   input  logic             Up,
   input  logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             LoadErr,
   output logic             Ovf
);
   localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic             at_end;
   logic             load_bad;
   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   step;
   logic [WIDTH-1:0] q_nxt;

   assign at_end   = Up ? Q == MAX : Q == '0;
   assign TC       = Enable & ~Load & at_end;
   assign load_bad = {1'b0, P} >= MOD;
   assign q_ext    = {1'b0, Q};
   assign step     = Up ? q_ext + 1'b1 : q_ext - 1'b1;

   // At a range end the step result is discarded: wrap to the far end or hold.
   always_comb
      q_nxt = at_end ? (SATURATE ? Q : (Up ? '0 : MAX)) : WIDTH'(step);

   always_ff @(posedge clk)
      if (!MR) begin
         Q       <= '0;
         LoadErr <= 1'b0;
         Ovf     <= 1'b0;
      end else begin
         LoadErr <= Load & load_bad;
         if (Load)
            Q <= load_bad ? MAX : P;
         else if (Enable) begin
            Q <= q_nxt;
            if (at_end) Ovf <= 1'b1;
         end
      end

`ifndef SYNTHESIS
   if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
      $fatal(1, "param_updown_counter: MODULUS out of range");
   end

   if (CHECK_EN) begin : g_chk
      logic mr_d;
      always_ff @(posedge clk) mr_d <= MR;
      always @(posedge clk) begin
         if (MR) begin
            assert (q_ext < MOD) else $error("Q out of range");
            assert (!$isunknown({Enable, Load, Up})) else $error("unknown control input");
         end
         if (!mr_d) assert (Q == '0) else $fatal(1, "reset not synchronous");
      end
   end
`endif
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: scoreboard bench; stimulus pushes model predictions,
// a monitor pops and compares them one step after each rising edge.
module tb_param_updown_counter;
   localparam int M = 10;

   typedef struct {
      int q, qs, lo, hi;
      bit le, ovf, tc, les, ovfs, tcs, lotc, hitc, loovf, hiovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       mr = 1'b0, en = 1'b0, ld = 1'b0, up = 1'b1, c_en = 1'b0;
   logic [3:0] p = '0;
   logic [3:0] q, qs, c_lo, c_hi;
   logic       tc, tcs, le, les, ovf, ovfs;
   logic       lo_tc, hi_tc, lo_le, hi_le, lo_ovf, hi_ovf;

   exp_t sb[$];
   int   checks = 0, failures = 0;

   int mq = 0, sq = 0, cnt = 0;
   bit mle = 0, movf = 0, sle = 0, sovf = 0, lo_w = 0, hi_w = 0;

   param_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(0)) dut (
      .clk(clk), .MR(mr), .Enable(en), .Load(ld), .Up(up), .P(p),
      .Q(q), .TC(tc), .LoadErr(le), .Ovf(ovf));

   param_updown_counter #(.WIDTH(4), .MODULUS(M), .SATURATE(1)) dut_s (
      .clk(clk), .MR(mr), .Enable(en), .Load(ld), .Up(up), .P(p),
      .Q(qs), .TC(tcs), .LoadErr(les), .Ovf(ovfs));

   param_updown_counter #(.WIDTH(4), .MODULUS(M)) lo (
      .clk(clk), .MR(mr), .Enable(c_en), .Load(1'b0), .Up(1'b1), .P(4'd0),
      .Q(c_lo), .TC(lo_tc), .LoadErr(lo_le), .Ovf(lo_ovf));

   param_updown_counter #(.WIDTH(4), .MODULUS(M)) hi (
      .clk(clk), .MR(mr), .Enable(lo_tc), .Load(1'b0), .Up(1'b1), .P(4'd0),
      .Q(c_hi), .TC(hi_tc), .LoadErr(hi_le), .Ovf(hi_ovf));

   function automatic void chk(string n, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", n, got, exp, $time);
      end
   endfunction

   // Reference: counting modulo M, with saturation as clamping at 0 / M-1.
   task automatic model(input bit sat, input bit r, e, l, u, input int pv,
                        inout int mq_, inout bit le_, inout bit ovf_);
      bit edge_hit;
      if (!r) begin
         mq_ = 0; le_ = 0; ovf_ = 0;
      end else if (l) begin
         le_ = pv >= M;
         mq_ = le_ ? M - 1 : pv;
      end else begin
         le_ = 0;
         if (e) begin
            edge_hit = u ? mq_ == M - 1 : mq_ == 0;
            if (edge_hit) ovf_ = 1;
            if (!(sat && edge_hit)) mq_ = u ? (mq_ + 1) % M : (mq_ + M - 1) % M;
         end
      end
   endtask

   task automatic step(input bit r, e, l, u, input int pv, input bit ce, input bit glitch);
      exp_t x;
      @(negedge clk);
      mr = r; en = e; ld = l; up = u; p = 4'(pv); c_en = ce;
      model(0, r, e, l, u, pv, mq, mle, movf);
      model(1, r, e, l, u, pv, sq, sle, sovf);
      if (!r) begin
         cnt = 0; lo_w = 0; hi_w = 0;
      end else if (ce) begin
         if (cnt % M == M - 1) lo_w = 1;
         if (cnt == M * M - 1) hi_w = 1;
         cnt = (cnt + 1) % (M * M);
      end
      x.q = mq; x.le = mle; x.ovf = movf;
      x.qs = sq; x.les = sle; x.ovfs = sovf;
      x.tc  = e && !l && (u ? mq == M - 1 : mq == 0);
      x.tcs = e && !l && (u ? sq == M - 1 : sq == 0);
      x.lo = cnt % M; x.hi = cnt / M;
      x.lotc = ce && cnt % M == M - 1;
      x.hitc = ce && cnt == M * M - 1;
      x.loovf = lo_w; x.hiovf = hi_w;
      sb.push_back(x);
      if (glitch) begin
         #1 mr = 1'b0;
         #1 mr = 1'b1;
      end
   endtask

   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("q", q, x.q);
            chk("loaderr", le, x.le);
            chk("ovf", ovf, x.ovf);
            chk("tc", tc, x.tc);
            chk("sat_q", qs, x.qs);
            chk("sat_loaderr", les, x.les);
            chk("sat_ovf", ovfs, x.ovfs);
            chk("sat_tc", tcs, x.tcs);
            chk("casc_lo", c_lo, x.lo);
            chk("casc_hi", c_hi, x.hi);
            chk("casc_lo_tc", lo_tc, x.lotc);
            chk("casc_hi_tc", hi_tc, x.hitc);
            chk("casc_loaderr", lo_le | hi_le, 0);
            chk("casc_lo_ovf", lo_ovf, x.loovf);
            chk("casc_hi_ovf", hi_ovf, x.hiovf);
         end
      end
   end

   initial begin
      bit r;
      step(0, 1, 0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0, 1, 0);
      step(1, 0, 0, 1, 0, 0, 1);
      step(1, 0, 1, 1, 7, 0, 0);
      repeat (3) step(1, 1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 1, 12, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 1, 1, 0, 0);
      repeat (2) step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 3, 0, 0);
      step(0, 1, 1, 1, 5, 0, 0);
      repeat (100) step(1, 0, 0, 1, 0, 1, 0);
      repeat (1500) begin
         r = $urandom_range(31) != 0;
         step(r, $urandom_range(3) != 0, $urandom_range(5) == 0, $urandom_range(3) != 0,
              int'($urandom_range(15)), $urandom_range(3) != 0, r && $urandom_range(15) == 0);
      end
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
